alu_share_sched: RTL
====================

// Module: alu_share_sched
// PURPOSE
//   Time-shares the single 2-cycle-latency ALU (op_start/operation/operand_a/operand_b -> result)
//   among NUM_REQ requesters. Round-robin arbitration, valid/ready request handshake, one
//   operation in flight. Sequences op_start and captures result, returning a registered
//   response to the granted requester. Sits between client blocks and the ALU instance.
// PARAMETERS
//   NUM_REQ      4  number of requesters (2..8)
//   ALU_LATENCY  2  cycles from the op_start cycle to the cycle in which result is valid (>=1)
// PORTS
//   clk            in   1          rising-edge clock
//   rst            in   1          synchronous, active-high reset
//   req_valid      in   NUM_REQ    per-requester request valid
//   req_ready      out  NUM_REQ    one-hot accept pulse; transfer when valid&ready
//   req_operation  in   2*NUM_REQ  packed per requester: [2*i+:2]; 00 ADD, 01 MULT, 10 OR, 11 AND
//   req_operand_a  in   8*NUM_REQ  packed per requester: [8*i+:8]
//   req_operand_b  in   8*NUM_REQ  packed per requester: [8*i+:8]
//   rsp_valid      out  NUM_REQ    one-hot, 1-cycle pulse to the requester that was served
//   rsp_result     out  16         registered result; valid while any rsp_valid is high
//   busy           out  1          high in every state except IDLE
//   op_start       out  1          to ALU; 1-cycle pulse
//   operation      out  2          to ALU
//   operand_a      out  8          to ALU
//   operand_b      out  8          to ALU
//   result         in   16         from ALU
// BEHAVIOUR
//   Reset: state=IDLE; req_ready, rsp_valid, op_start, busy=0; operation, operand_a/b,
//     rsp_result=0; rr pointer=NUM_REQ-1 (requester 0 has first priority). rst wins over all.
//   FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE: if |req_valid, grant g = first valid index after the rr pointer (wrapping modulo
//     NUM_REQ). Assert req_ready[g] combinationally this cycle only. At the clock edge, latch
//     req_operation/a/b[g] into the ALU-driving registers, store g, set rr pointer=g,
//     go to ISSUE. If there is no valid request, stay in IDLE with all req_ready=0.
//   ISSUE: op_start=1 for exactly this cycle (cycle T); operands are held from ISSUE through
//     the end of WAIT. Counter=ALU_LATENCY-1. Go to WAIT.
//   WAIT: decrement each cycle. In cycle T+ALU_LATENCY (counter==0), capture result into
//     rsp_result at the clock edge. Go to RESP.
//   RESP: rsp_valid[g]=1 for this cycle only (cycle T+ALU_LATENCY+1). req_ready stays 0.
//     Go to IDLE.
//   Throughput: one operation per ALU_LATENCY+3 cycles (5 at default). The accept-to-rsp_valid
//     delay is ALU_LATENCY+2 cycles.
//   req_ready is never asserted outside IDLE. A requester holds valid and payload until it
//     is accepted. A valid that is withdrawn before acceptance is dropped silently.
//   Arithmetic belongs to the ALU: ADD and MULT are zero-extended to 16 bits; OR and AND
//     return {8'h00, a op b}. This block does not modify result.
//   Reset mid-operation (ISSUE, WAIT or RESP): the in-flight operation is abandoned, with no
//     rsp_valid. The first cycle after reset is IDLE, and op_start=0 during it.
//   Simultaneous requests: round-robin only, with no starvation. Each requester waits at most
//     NUM_REQ-1 services.
// STRUCTURE
//   alu_sched_pkg: alu_op_e enum (ADD=2'b00, MULT=2'b01, OR=2'b10, AND=2'b11),
//     sched_state_e enum (IDLE, ISSUE, WAIT, RESP), OPERAND_W=8, RESULT_W=16.
//   Sub-module rr_arbiter #(N): purely combinational. Inputs: req vector and last-grant
//     pointer. Outputs: one-hot grant and grant index. The pointer register lives in
//     alu_share_sched.
// TESTING
//   1. Requester 0 only: ADD a=200, b=100 -> req_ready[0] in the accept cycle;
//      rsp_valid[0] 4 cycles later; rsp_result=16'd300.
//   2. Requester 2: MULT a=255, b=255 -> rsp_valid[2], rsp_result=16'd65025; op_start pulses
//      exactly once.
//   3. All 4 requesters valid continuously -> grant order 0,1,2,3,0. Each rsp_valid is
//      one-hot and matches its requester's OR/AND expected value, e.g. OR 8'hF0|8'h0F=16'h00FF.
//   4. Requesters 1 and 3 valid after serving 1 -> 3 is served next, then 1.
//      Requester 0 joining later waits no more than 1 service.
//   5. rst asserted in WAIT -> next cycle: state IDLE, busy=0, no rsp_valid ever for that op.
//      The next request from requester 0 completes correctly.
//   6. Self-checking scoreboard: 200 random ops from random requesters -> every rsp_result
//      equals the ADD/MULT/OR/AND model, and no req_ready occurs while busy.

Source files
------------

// File: rtl/alu_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_sched_pkg
// Brief    : Shared types and widths for the ALU time-sharing scheduler.
// Revision : 1.0
// ============================================================================
package alu_sched_pkg;

    typedef enum logic [1:0] {
        ADD  = 2'b00,
        MULT = 2'b01,
        OR   = 2'b10,
        AND  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } sched_state_e;

    localparam int OPERAND_W = 8;
    localparam int RESULT_W  = 16;

endpackage
`default_nettype wire

// File: rtl/alu_share_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter; the search starts just after
//            the last-grant pointer and wraps modulo N.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    always_comb begin
        int w_j;
        logic w_any;
        grant     = '0;
        grant_idx = '0;
        w_any     = 1'b0;
        w_j       = 0;
        // Walk from farthest to nearest so the nearest requester wins.
        for (int k = N; k >= 1; k--) begin
            w_j = (int'(last) + k) % N;
            if (req[w_j]) begin
                grant_idx = IDX_W'(w_j);
                w_any     = 1'b1;
            end
        end
        if (w_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_sched
// Brief    : Round-robin time-sharing of one fixed-latency ALU among
//            NUM_REQ requesters, one operation in flight.
// Revision : 1.0
// ============================================================================
module alu_share_sched
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ALU_LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [2*NUM_REQ-1:0]        req_operation,
    input  logic [OPERAND_W*NUM_REQ-1:0] req_operand_a,
    input  logic [OPERAND_W*NUM_REQ-1:0] req_operand_b,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [RESULT_W-1:0]         rsp_result,
    output logic                        busy,
    output logic                        op_start,
    output logic [1:0]                  operation,
    output logic [OPERAND_W-1:0]        operand_a,
    output logic [OPERAND_W-1:0]        operand_b,
    input  logic [RESULT_W-1:0]         result
);

    localparam int c_idx_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_cnt_w = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

    sched_state_e          r_state;
    sched_state_e          w_next_state;
    logic [c_idx_w-1:0]    r_rr_ptr;
    logic [c_idx_w-1:0]    r_grant_idx;
    logic [c_cnt_w-1:0]    r_cnt;
    alu_op_e               r_operation;
    logic [OPERAND_W-1:0]  r_operand_a;
    logic [OPERAND_W-1:0]  r_operand_b;
    logic [RESULT_W-1:0]   r_rsp_result;
    logic [NUM_REQ-1:0]    w_grant;
    logic [c_idx_w-1:0]    w_grant_idx;
    logic                  w_any_req;

    assign w_any_req = |req_valid;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (c_idx_w)
    ) u_arb (
        .req       (req_valid),
        .last      (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rr_ptr     <= c_idx_w'(NUM_REQ - 1);
            r_grant_idx  <= '0;
            r_cnt        <= '0;
            r_operation  <= ADD;
            r_operand_a  <= '0;
            r_operand_b  <= '0;
            r_rsp_result <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_operation <= alu_op_e'(req_operation[2*w_grant_idx +: 2]);
                        r_operand_a <= req_operand_a[OPERAND_W*w_grant_idx +: OPERAND_W];
                        r_operand_b <= req_operand_b[OPERAND_W*w_grant_idx +: OPERAND_W];
                        r_grant_idx <= w_grant_idx;
                        r_rr_ptr    <= w_grant_idx;
                    end
                end
                ISSUE: r_cnt <= c_cnt_w'(ALU_LATENCY - 1);
                WAIT: begin
                    // Counter reaches zero exactly in the cycle the ALU result is valid.
                    if (r_cnt == '0) begin
                        r_rsp_result <= result;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = '0;
        op_start     = 1'b0;
        rsp_valid    = '0;
        case (r_state)
            IDLE: begin
                if (w_any_req && !rst) begin
                    req_ready    = w_grant;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                op_start     = 1'b1;
                w_next_state = WAIT;
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                rsp_valid[r_grant_idx] = 1'b1;
                w_next_state           = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign busy       = (r_state != IDLE);
    assign operation  = r_operation;
    assign operand_a  = r_operand_a;
    assign operand_b  = r_operand_b;
    assign rsp_result = r_rsp_result;

endmodule
`default_nettype wire
